// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if
// Groups the two streaming sides of the frame parser:
//   - receiver FIFO read side : fifo_empty, fifo_dout (in to parser), fifo_rd_en (out)
//   - payload stream side     : out_data, out_valid, out_last (out), out_ready (in)
// master : the parser (drives fifo_rd_en and the out_* stream)
// slave  : the environment (receiver FIFO and payload consumer)
interface uart_frame_parser_if;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        input  fifo_empty, fifo_dout, out_ready,
        output fifo_rd_en, out_data, out_valid, out_last
    );

    modport slave (
        output fifo_empty, fifo_dout, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_last
    );
endinterface

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Drains the UART receiver FIFO, hunts for SYNC_BYTE, parses CMD/LEN, buffers
// up to MAX_LEN payload bytes, checks the 8-bit additive checksum and only then
// releases the payload on a valid/ready stream.
// Wire format: SYNC, CMD, LEN, LEN payload bytes, CHK = (CMD+LEN+payload) mod 256.
//
// Ports:
//   clk, srst            clock, synchronous active-high reset
//   bus (master)         fifo_empty/fifo_dout/fifo_rd_en and out_data/out_valid/out_ready/out_last
//   frame_cmd/frame_len  CMD/LEN of the last good frame
//   frame_done           one-cycle pulse once a good frame is fully delivered
//   err_pulse/err_code   one-cycle error pulse; 1 = bad checksum, 2 = LEN > MAX_LEN, 3 = timeout
//
// Build option: define UART_FRAME_TIMEOUT_EN to add the inter-byte timeout
// (TIMEOUT_CYCLES idle cycles inside a frame abort it with err_code 3).
module uart_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          MAX_LEN        = 64,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd20000
) (
    input  logic                clk,
    input  logic                srst,
    uart_frame_parser_if.master bus,
    output logic [7:0]          frame_cmd,
    output logic [7:0]          frame_len,
    output logic                frame_done,
    output logic                err_pulse,
    output logic [1:0]          err_code
);
    localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("uart_frame_parser: MAX_LEN must be 1..255");
    end
    if (TIMEOUT_CYCLES == 32'd0) begin : g_bad_timeout
        $error("uart_frame_parser: TIMEOUT_CYCLES must be nonzero");
    end

    typedef enum logic [2:0] {
        S_HUNT, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_EMIT
    } state_t;

    state_t     state;
    logic       in_flight;   // a read was accepted last cycle; fifo_dout is valid now
    logic [7:0] cur_cmd;
    logic [7:0] cur_len;
    logic [7:0] cnt;         // payload write index, then emit read index
    logic [7:0] sum;
    logic [7:0] rx;
    logic [7:0] nxt;
    logic [7:0] pay_mem [0:MAX_LEN-1];

    assign rx  = bus.fifo_dout;
    assign nxt = cnt + 8'd1;

    // Combinational so a read can be issued the same cycle the FIFO goes
    // non-empty; the in-flight flag limits us to one outstanding byte.
    assign bus.fifo_rd_en = !srst && !bus.fifo_empty && !in_flight && (state != S_EMIT);

    // Payload buffer: plain RAM, no reset needed.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && in_flight)
            pay_mem[cnt[IW-1:0]] <= rx;
    end

`ifdef UART_FRAME_TIMEOUT_EN
    logic [31:0] tcnt;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            state         <= S_HUNT;
            in_flight     <= 1'b0;
            cur_cmd       <= '0;
            cur_len       <= '0;
            cnt           <= '0;
            sum           <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            frame_cmd     <= '0;
            frame_len     <= '0;
            frame_done    <= 1'b0;
            err_pulse     <= 1'b0;
            err_code      <= '0;
`ifdef UART_FRAME_TIMEOUT_EN
            tcnt          <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            err_pulse  <= 1'b0;
            in_flight  <= bus.fifo_rd_en;

            case (state)
                S_HUNT: begin
                    if (in_flight && rx == SYNC_BYTE) begin
                        sum   <= '0;
                        state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (in_flight) begin
                        cur_cmd <= rx;
                        sum     <= sum + rx;
                        state   <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (in_flight) begin
                        if (rx > MAX_LEN_B) begin
                            err_pulse <= 1'b1;
                            err_code  <= 2'd2;
                            state     <= S_HUNT;
                        end else begin
                            cur_len <= rx;
                            sum     <= sum + rx;
                            cnt     <= '0;
                            state   <= (rx == 8'd0) ? S_CHK : S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (in_flight) begin
                        sum <= sum + rx;
                        if (cnt == cur_len - 8'd1)
                            state <= S_CHK;
                        else
                            cnt <= nxt;
                    end
                end
                S_CHK: begin
                    if (in_flight) begin
                        if (rx == sum) begin
                            frame_cmd <= cur_cmd;
                            frame_len <= cur_len;
                            if (cur_len == 8'd0) begin
                                frame_done <= 1'b1;
                                state      <= S_HUNT;
                            end else begin
                                // First beat is presented straight away.
                                cnt           <= '0;
                                bus.out_valid <= 1'b1;
                                bus.out_data  <= pay_mem[0];
                                bus.out_last  <= (cur_len == 8'd1);
                                state         <= S_EMIT;
                            end
                        end else begin
                            err_pulse <= 1'b1;
                            err_code  <= 2'd1;
                            state     <= S_HUNT;
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.out_valid && bus.out_ready) begin
                        if (bus.out_last) begin
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            frame_done    <= 1'b1;
                            state         <= S_HUNT;
                        end else begin
                            cnt          <= nxt;
                            bus.out_data <= pay_mem[nxt[IW-1:0]];
                            bus.out_last <= (nxt == cur_len - 8'd1);
                        end
                    end
                end
                default: state <= S_HUNT;
            endcase

`ifdef UART_FRAME_TIMEOUT_EN
            // Only fires on a cycle with no byte arriving, so it never
            // competes with the state updates above.
            if (state == S_CMD || state == S_LEN || state == S_PAYLOAD || state == S_CHK) begin
                if (in_flight) begin
                    tcnt <= '0;
                end else if (tcnt == TIMEOUT_CYCLES - 32'd1) begin
                    tcnt      <= '0;
                    err_pulse <= 1'b1;
                    err_code  <= 2'd3;
                    state     <= S_HUNT;
                end else begin
                    tcnt <= tcnt + 32'd1;
                end
            end else begin
                tcnt <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
// Randomized and directed stimulus for uart_frame_parser. A byte-queue FIFO
// model feeds the DUT; a monitor turns outputs into an event list (beats,
// frame_done, err_pulse) compared against a stream-level frame model.
module tb_uart_frame_parser;
    localparam int MAXL = 64;
    localparam int TMO  = 100;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       srst;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic       frame_done;
    logic       err_pulse;
    logic [1:0] err_code;

    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (MAXL),
        .TIMEOUT_CYCLES (32'(TMO))
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .bus        (bus),
        .frame_cmd  (frame_cmd),
        .frame_len  (frame_len),
        .frame_done (frame_done),
        .err_pulse  (err_pulse),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  fq [$];
    int          pop_log [$];
    int          cyc = 0;
    bit          pop_now;
    int          ready_mode = 0;
    int          rdy_st = 0;
    logic [31:0] ev [$];
    int          ev_cyc [$];
    logic [31:0] exp_q [$];
    int          rd_viol = 0;
    int          stall_viol = 0;
    int          both_viol = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [7:0]  pd = '0;

    // Receiver FIFO model: data appears one cycle after an accepted read.
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        forever begin
            @(negedge clk);
            pop_now = bus.fifo_rd_en && (fq.size() > 0);
            @(posedge clk);
            cyc++;
            #1;
            if (pop_now) begin
                bus.fifo_dout = fq.pop_front();
                pop_log.push_back(cyc);
            end
            bus.fifo_empty = (fq.size() == 0);
        end
    end

    // Consumer: 0 = always ready, 1 = random, 2 = 5 stall cycles per beat.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.out_valid) begin
                        if (rdy_st < 5) begin
                            bus.out_ready = 1'b0;
                            rdy_st++;
                        end else begin
                            bus.out_ready = 1'b1;
                            rdy_st = 0;
                        end
                    end else begin
                        bus.out_ready = 1'b0;
                        rdy_st = 0;
                    end
                end
            endcase
        end
    end

    // Event monitor plus protocol invariants.
    always @(negedge clk) begin
        if (!srst) begin
            if (bus.out_valid && bus.out_ready) begin
                ev.push_back({2'd1, 21'd0, bus.out_last, bus.out_data});
                ev_cyc.push_back(cyc);
            end
            if (frame_done) begin
                ev.push_back({2'd2, 14'd0, frame_cmd, frame_len});
                ev_cyc.push_back(cyc);
            end
            if (err_pulse) begin
                ev.push_back({2'd3, 28'd0, err_code});
                ev_cyc.push_back(cyc);
            end
            if (bus.fifo_rd_en && bus.out_valid) rd_viol++;
            if (frame_done && err_pulse) both_viol++;
            if (pv && !pr && !(bus.out_valid && bus.out_data == pd)) stall_viol++;
        end
        pv = srst ? 1'b0 : bus.out_valid;
        pr = bus.out_ready;
        pd = bus.out_data;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stream-level reference: walks the byte list frame by frame.
    task automatic model(input bq_t s);
        int i;
        int n;
        int len;
        logic [7:0] cmd;
        logic [7:0] sum;
        exp_q.delete();
        i = 0;
        n = s.size();
        while (i < n) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            if (i + 2 >= n) break;
            cmd = s[i+1];
            len = int'(s[i+2]);
            if (len > MAXL) begin
                exp_q.push_back({2'd3, 28'd0, 2'd2});
                i += 3;
                continue;
            end
            if (i + 3 + len >= n) break;
            sum = cmd + s[i+2];
            for (int k = 0; k < len; k++) sum = sum + s[i+3+k];
            if (s[i+3+len] == sum) begin
                for (int k = 0; k < len; k++)
                    exp_q.push_back({2'd1, 21'd0, (k == len - 1), s[i+3+k]});
                exp_q.push_back({2'd2, 14'd0, cmd, s[i+2]});
            end else begin
                exp_q.push_back({2'd3, 28'd0, 2'd1});
            end
            i += 4 + len;
        end
    endtask

    task automatic push_bytes(input bq_t s);
        foreach (s[k]) fq.push_back(s[k]);
        bus.fifo_empty = (fq.size() == 0);
    endtask

    task automatic clear_logs();
        ev.delete();
        ev_cyc.delete();
        pop_log.delete();
    endtask

    // Waits for the FIFO to empty and the DUT to go quiet.
    task automatic drain(input int budget, output bit ok);
        int quiet;
        quiet = 0;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #2;
            if (fq.size() == 0 && !bus.out_valid && !bus.fifo_rd_en) quiet++;
            else quiet = 0;
            if (quiet >= 8) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        srst = 1'b1;
        push_bytes('{8'h3C});
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (bus.fifo_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en);
        end
        n_chk++;
        if ({bus.out_valid, bus.out_last, frame_done, err_pulse} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0000", {bus.out_valid, bus.out_last, frame_done, err_pulse});
        end
        n_chk++;
        if ({bus.out_data, frame_cmd, frame_len, err_code} !== 26'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", {bus.out_data, frame_cmd, frame_len, err_code});
        end
        clear_logs();
        srst = 1'b0;
        drain(200, ok);
        n_chk++;
        if (ok !== 1'b1 || ev.size() != 0 || pop_log.size() != 1) begin
            n_err++;
            $display("FAIL reset_garbage: drain=%b events=%0d pops=%0d want 1/0/1", ok, ev.size(), pop_log.size());
        end
    endtask

    task automatic test_good_frame();
        bq_t s;
        bit ok;
        int p;
        clear_logs();
        s = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        model(s);
        push_bytes(s);
        drain(300, ok);
        n_chk++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL good_drain: got %b want 1", ok); end
        n_chk++;
        if (ev.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL good_count: got %0d events want %0d", ev.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_chk++;
                if (ev[k] !== exp_q[k]) begin
                    n_err++;
                    $display("FAIL good_ev%0d: got %h want %h", k, ev[k], exp_q[k]);
                end
            end
            p = pop_log[pop_log.size()-1];
            n_chk++;
            if (ev_cyc[0] != p + 1 || ev_cyc[2] != p + 3) begin
                n_err++;
                $display("FAIL good_latency: beat0 at %0d done at %0d want %0d/%0d", ev_cyc[0], ev_cyc[2], p + 1, p + 3);
            end
        end
        n_chk++;
        if (frame_cmd !== 8'h01 || frame_len !== 8'h02) begin
            n_err++;
            $display("FAIL good_hdr: got %h/%h want 01/02", frame_cmd, frame_len);
        end
    endtask

    task automatic test_bad_chk();
        bq_t s;
        bit ok;
        clear_logs();
        s = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34,
              8'hA5, 8'h07, 8'h00, 8'h07};
        model(s);
        push_bytes(s);
        drain(300, ok);
        n_chk++;
        if (ok !== 1'b1 || ev.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL badchk_count: drain=%b got %0d events want %0d", ok, ev.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_chk++;
                if (ev[k] !== exp_q[k]) begin
                    n_err++;
                    $display("FAIL badchk_ev%0d: got %h want %h", k, ev[k], exp_q[k]);
                end
            end
        end
        n_chk++;
        if (frame_cmd !== 8'h07 || frame_len !== 8'h00) begin
            n_err++;
            $display("FAIL badchk_hdr: got %h/%h want 07/00", frame_cmd, frame_len);
        end
    endtask

    task automatic test_overlen();
        bq_t s;
        bit ok;
        clear_logs();
        s = '{8'hA5, 8'h01, 8'h41, 8'hA5, 8'h02, 8'h01, 8'hAA, 8'hAD};
        model(s);
        push_bytes(s);
        drain(300, ok);
        n_chk++;
        if (ok !== 1'b1 || ev.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL overlen_count: drain=%b got %0d events want %0d", ok, ev.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_chk++;
                if (ev[k] !== exp_q[k]) begin
                    n_err++;
                    $display("FAIL overlen_ev%0d: got %h want %h", k, ev[k], exp_q[k]);
                end
            end
            n_chk++;
            if (ev_cyc[0] != pop_log[2] + 1) begin
                n_err++;
                $display("FAIL overlen_timing: err at %0d want %0d", ev_cyc[0], pop_log[2] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        bq_t s;
        bit ok;
        logic [7:0] d0, d1, d2, e0, e1;
        clear_logs();
        ready_mode = 2;
        d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        e0 = 8'($urandom); e1 = 8'($urandom);
        s = '{8'hA5, 8'h33, 8'h03, d0, d1, d2, 8'(8'h33 + 8'h03 + d0 + d1 + d2),
              8'hA5, 8'h44, 8'h02, e0, e1, 8'(8'h44 + 8'h02 + e0 + e1)};
        model(s);
        push_bytes(s);
        drain(600, ok);
        n_chk++;
        if (ok !== 1'b1 || ev.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL bp_count: drain=%b got %0d events want %0d", ok, ev.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_chk++;
                if (ev[k] !== exp_q[k]) begin
                    n_err++;
                    $display("FAIL bp_ev%0d: got %h want %h", k, ev[k], exp_q[k]);
                end
            end
            n_chk++;
            if (ev_cyc[1] - ev_cyc[0] != 6 || ev_cyc[2] - ev_cyc[1] != 6) begin
                n_err++;
                $display("FAIL bp_spacing: got %0d/%0d want 6/6", ev_cyc[1] - ev_cyc[0], ev_cyc[2] - ev_cyc[1]);
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_timeout();
        bq_t s;
        bit ok;
        clear_logs();
        push_bytes('{8'hA5, 8'h01});
`ifdef UART_FRAME_TIMEOUT_EN
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #2;
            if (ev.size() > 0) break;
        end
        n_chk++;
        if (ev.size() != 1 || ev[0] !== {2'd3, 28'd0, 2'd3}) begin
            n_err++;
            $display("FAIL timeout_err: got %0d events first %h want 1 event %h", ev.size(),
                     (ev.size() > 0) ? ev[0] : 32'd0, {2'd3, 28'd0, 2'd3});
        end else begin
            n_chk++;
            if (ev_cyc[0] - pop_log[1] != TMO + 1) begin
                n_err++;
                $display("FAIL timeout_cycles: got %0d want %0d", ev_cyc[0] - pop_log[1], TMO + 1);
            end
        end
        clear_logs();
        s = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        push_bytes(s);
`else
        repeat (1000) @(posedge clk);
        #2;
        n_chk++;
        if (ev.size() != 0) begin
            n_err++;
            $display("FAIL timeout_idle: got %0d events want 0", ev.size());
        end
        s = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        push_bytes('{8'h02, 8'h10, 8'h20, 8'h33});
`endif
        model(s);
        drain(300, ok);
        n_chk++;
        if (ok !== 1'b1 || ev.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL timeout_frame_count: drain=%b got %0d events want %0d", ok, ev.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_chk++;
                if (ev[k] !== exp_q[k]) begin
                    n_err++;
                    $display("FAIL timeout_frame_ev%0d: got %h want %h", k, ev[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        bq_t s;
        bit ok;
        bit seen;
        logic [7:0] d [4];
        logic [7:0] sum;
        clear_logs();
        ready_mode = 0;
        sum = 8'h5A + 8'h04;
        foreach (d[k]) begin
            d[k] = 8'($urandom);
            sum = sum + d[k];
        end
        s = '{8'hA5, 8'h5A, 8'h04, d[0], d[1], d[2], d[3], sum};
        push_bytes(s);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!seen) begin
            n_err++;
            $display("FAIL rst_emit_start: out_valid never rose");
        end else begin
            @(posedge clk);
            #1;
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== d[1]) begin
                n_err++;
                $display("FAIL rst_emit_beat1: got %b/%h want 1/%h", bus.out_valid, bus.out_data, d[1]);
            end
            srst = 1'b1;
            @(posedge clk);
            #1;
            srst = 1'b0;
            n_chk++;
            if (bus.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_emit_valid: got %b want 0", bus.out_valid);
            end
        end
        drain(200, ok);
        n_chk++;
        if (ok !== 1'b1 || ev.size() != 1 || ev[0] !== {2'd1, 21'd0, 1'b0, d[0]}) begin
            n_err++;
            $display("FAIL rst_emit_events: drain=%b got %0d events want only first beat %h", ok, ev.size(), d[0]);
        end
        clear_logs();
        s = '{8'hA5, 8'h09, 8'h01, 8'h77, 8'h81};
        model(s);
        push_bytes(s);
        drain(300, ok);
        n_chk++;
        if (ok !== 1'b1 || ev.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rst_emit_next_count: drain=%b got %0d events want %0d", ok, ev.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_chk++;
                if (ev[k] !== exp_q[k]) begin
                    n_err++;
                    $display("FAIL rst_emit_next_ev%0d: got %h want %h", k, ev[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        bq_t s;
        bit ok;
        int len;
        logic [7:0] cmd;
        logic [7:0] b;
        logic [7:0] sum;
        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            clear_logs();
            s.delete();
            for (int f = 0; f < int'($urandom_range(2, 4)); f++) begin
                repeat ($urandom_range(0, 3)) begin
                    b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h00;
                    s.push_back(b);
                end
                case ($urandom_range(0, 7))
                    0: len = 0;
                    1: len = 1;
                    2: len = MAXL;
                    3: len = MAXL + 1;
                    4: len = 255;
                    default: len = int'($urandom_range(2, 10));
                endcase
                cmd = 8'($urandom);
                s.push_back(8'hA5);
                s.push_back(cmd);
                s.push_back(8'(len));
                if (len > MAXL) continue;
                sum = cmd + 8'(len);
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom);
                    s.push_back(b);
                    sum = sum + b;
                end
                if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
                s.push_back(sum);
            end
            model(s);
            push_bytes(s);
            drain(8000, ok);
            n_chk++;
            if (ok !== 1'b1 || ev.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL rand%0d_count: drain=%b got %0d events want %0d", r, ok, ev.size(), exp_q.size());
            end else begin
                foreach (exp_q[k]) begin
                    n_chk++;
                    if (ev[k] !== exp_q[k]) begin
                        n_err++;
                        $display("FAIL rand%0d_ev%0d: got %h want %h", r, k, ev[k], exp_q[k]);
                    end
                end
            end
        end
        ready_mode = 0;
    endtask

    initial begin
        srst = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_overlen();
        test_backpressure();
        test_timeout();
        test_reset_mid_emit();
        test_random();
        n_chk++;
        if (rd_viol != 0) begin
            n_err++;
            $display("FAIL no_read_in_emit: got %0d reads during EMIT want 0", rd_viol);
        end
        n_chk++;
        if (stall_viol != 0) begin
            n_err++;
            $display("FAIL stall_stable: got %0d unstable stalled beats want 0", stall_viol);
        end
        n_chk++;
        if (both_viol != 0) begin
            n_err++;
            $display("FAIL done_err_exclusive: got %0d overlaps want 0", both_viol);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
